power_seq: RTL and testbench
============================

Name: power_seq

Overview:
- Multi-rail power sequencer. A single debounced power button brings NCH enable rails up in ascending order and down in descending order, one rail per programmable step interval.
- Adds long-press forced-off, reversal of a sequence in progress, an idle auto-off timer, and a status readout.
- Sits between the board power button and the per-domain enables. Driven by the main controller's done/activity strobes.

Parameters:
- NCH, 4, number of rails (>=1); pwr_en width.
- DEB_CMAX, `c_ms(5), debounce interval in clk cycles (>=1).
- STEP_CMAX, `c_ms(10), cycles between successive rail changes (>=1).
- HOLD_CMAX, `c_ms(2000), press length in cycles that counts as a long press; must be > DEB_CMAX.
- IDLE_CMAX, 0, cycles in ON with no activity before auto-off; 0 disables the timer.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- a_pwr  in  1  raw power button, asynchronous, active-high.
- main_done  in  1  one-cycle strobe from main controller: request power-down.
- activity  in  1  one-cycle strobe: restarts the idle timer.
- lock  in  1  1 = button ignored.
- pwr_en  out  NCH  rail enables, thermometer code from bit 0.
- led_pwr  out  1  1 when state != OFF.
- busy  out  1  1 in UP or DOWN.
- st  out  2  state: OFF=0, UP=1, ON=2, DOWN=3.

Behaviour:
- Reset (async): state OFF; pwr_en=0; led_pwr=0; busy=0; st=0; all counters, sync flops and debounced level cleared. Assertion mid-sequence drops every rail immediately.
- Input conditioning:
  - a_pwr passes through a 2-flop synchroniser.
  - The debounced level changes only after the synchronised input has differed from it for DEB_CMAX consecutive cycles.
  - While lock=1: debounce counter held at 0, level frozen, hold counter cleared, no events generated.
- Events (at most one per press):
  - Hold counter runs while the debounced level is 1.
  - Reaching HOLD_CMAX emits LONG once; the subsequent release emits nothing.
  - A falling debounced edge before HOLD_CMAX emits SHORT on that cycle.
- State transitions (priority LONG > main_done > idle expiry > SHORT):
  - OFF: SHORT -> UP. main_done and idle ignored.
  - UP: LONG -> OFF. main_done -> DOWN. SHORT -> DOWN.
  - ON: LONG -> OFF. main_done -> DOWN. idle expiry -> DOWN. SHORT -> DOWN.
  - DOWN: LONG -> OFF. SHORT -> UP, unless main_done is asserted in the same cycle, in which case the block stays in DOWN.
  - LONG -> OFF clears pwr_en on the same edge as the transition.
- Sequencing, with E = the edge that enters UP or DOWN:
  - UP: the lowest cleared bit of pwr_en sets at E+1, then one more bit every STEP_CMAX cycles.
  - UP -> ON on the same edge that sets bit NCH-1.
  - DOWN: the highest set bit clears at E+1, then one more bit every STEP_CMAX cycles.
  - DOWN -> OFF on the same edge that clears bit 0.
  - A reversal mid-sequence restarts the step counter and continues from the current pwr_en; no bit toggles twice in one cycle.
  - Entering UP with pwr_en already full (unreachable) goes straight to ON at E+1; same for DOWN with pwr_en empty (goes to OFF).
- Idle timer (IDLE_CMAX>0):
  - Counts only in ON.
  - Cleared on entry to ON, and by activity or any debounced press edge.
  - Expires on the cycle the count reaches IDLE_CMAX.
- Counter widths: each sized by $clog2 of its max+1. Counters saturate and never wrap.
- Outputs are registered; st, busy and led_pwr update on the same edge as the state.

Test Plan (NCH=3, DEB_CMAX=4, STEP_CMAX=8, HOLD_CMAX=40, IDLE_CMAX=100):
1. From OFF, a_pwr high 12 cycles then low -> SHORT; st=UP; pwr_en 001, then 011 eight cycles later, then 111 eight cycles after that; st=ON, led_pwr=1, busy=0.
2. In ON, repeat the short press -> pwr_en 011, 001, 000 spaced by 8 cycles; st=OFF, led_pwr=0.
3. In UP right after pwr_en=011, give a short press -> st=DOWN; pwr_en=001 one cycle after the event; pwr_en=000 eight cycles later; st=OFF.
4. In ON, hold a_pwr 60 cycles -> pwr_en=000 and st=OFF on the edge the hold count hits 40; the release causes no further change.
5. In ON, press with lock=1 -> no change. Then pulse main_done -> DOWN sequence. Then power up again and pulse activity at cycle 90 of ON -> no expiry until 100 quiet cycles after the pulse, then DOWN.
6. Drop rst_n mid-UP (pwr_en=011) -> pwr_en=000, st=0 without waiting for a clk edge. After release, the block stays OFF until the next press.

Source files
------------

// File: rtl/power_seq.sv
// ---------------------------------------------------------------------------
// power_seq : multi-rail power sequencer
//
// One debounced power button brings NCH rail enables up in ascending order
// and down in descending order, one rail per STEP_CMAX cycles. It also
// supports a long-press forced off, reversal of a sequence in progress, an
// idle auto-off timer in ON, and a state readout.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset; drops every rail at once
//   a_pwr      raw power button, asynchronous, active-high
//   main_done  one-cycle strobe from the main controller: request power-down
//   activity   one-cycle strobe: restarts the idle timer
//   lock       1 = button ignored
//   pwr_en     rail enables, thermometer code from bit 0
//   led_pwr    1 whenever the state is not OFF
//   busy       1 in UP or DOWN
//   st         state: OFF=0, UP=1, ON=2, DOWN=3
// ---------------------------------------------------------------------------
`ifndef C_MS
// Milliseconds to clk cycles for the default 50 MHz system clock.
`define C_MS(ms) ((ms) * 50000)
`endif

module power_seq #(
   parameter int NCH       = 4,
   parameter int DEB_CMAX  = `C_MS(5),
   parameter int STEP_CMAX = `C_MS(10),
   parameter int HOLD_CMAX = `C_MS(2000),
   parameter int IDLE_CMAX = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           a_pwr,
   input  logic           main_done,
   input  logic           activity,
   input  logic           lock,
   output logic [NCH-1:0] pwr_en,
   output logic           led_pwr,
   output logic           busy,
   output logic [1:0]     st
);

   localparam logic [1:0] S_OFF  = 2'd0;
   localparam logic [1:0] S_UP   = 2'd1;
   localparam logic [1:0] S_ON   = 2'd2;
   localparam logic [1:0] S_DOWN = 2'd3;

   localparam int DW = $clog2(DEB_CMAX + 1);
   localparam int HW = $clog2(HOLD_CMAX + 1);
   localparam int SW = $clog2(STEP_CMAX + 1);
   localparam int IW = (IDLE_CMAX > 0) ? $clog2(IDLE_CMAX + 1) : 1;

   localparam logic [DW-1:0]  DEB_LAST  = DW'(DEB_CMAX - 1);
   localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CMAX - 1);
   localparam logic [HW-1:0]  HOLD_MAX  = HW'(HOLD_CMAX);
   localparam logic [SW-1:0]  STEP_LAST = SW'(STEP_CMAX - 1);
   localparam logic [IW-1:0]  IDLE_LAST = IW'((IDLE_CMAX > 0) ? IDLE_CMAX - 1 : 0);
   localparam logic [IW-1:0]  IDLE_MAX  = IW'(IDLE_CMAX);
   localparam logic [NCH-1:0] RAIL_ONE  = NCH'(1);

   logic           a_meta_reg,   a_sync_reg;
   logic           deb_lvl_reg,  deb_lvl_next;
   logic [DW-1:0]  deb_cnt_reg,  deb_cnt_next;
   logic [HW-1:0]  hold_cnt_reg, hold_cnt_next;
   logic [IW-1:0]  idle_cnt_reg, idle_cnt_next;
   logic [SW-1:0]  step_cnt_reg, step_cnt_next;
   logic [1:0]     state_reg,    state_next;
   logic [NCH-1:0] pwr_en_reg,   pwr_en_next;
   logic           led_reg,      led_next;
   logic           busy_reg,     busy_next;

   logic           deb_diff, deb_flip, long_evt, short_evt;
   logic           idle_clr, idle_exp, step_tick, enter_seq;
   logic [NCH-1:0] up_val, dn_val;

   // Button events are decoded on the edge where the counters reach their
   // limit, so a state change lands on the same edge as the event itself.
   always_comb begin
      deb_diff  = (a_sync_reg != deb_lvl_reg);
      deb_flip  = !lock && deb_diff && (deb_cnt_reg == DEB_LAST);
      long_evt  = !lock && deb_lvl_reg && (hold_cnt_reg == HOLD_LAST);
      // A release on the very edge the hold limit is reached is a LONG press.
      short_evt = deb_flip && deb_lvl_reg && (hold_cnt_reg < HOLD_LAST);
      idle_clr  = activity || deb_flip;
      idle_exp  = (IDLE_CMAX > 0) && (state_reg == S_ON) && !idle_clr &&
                  (idle_cnt_reg == IDLE_LAST);
      step_tick = (step_cnt_reg == STEP_LAST);
      up_val    = (pwr_en_reg << 1) | RAIL_ONE;
      dn_val    = pwr_en_reg >> 1;
   end

   // Input conditioning: debounce and press-length counters.
   always_comb begin
      deb_lvl_next  = deb_lvl_reg;
      deb_cnt_next  = '0;
      hold_cnt_next = '0;
      idle_cnt_next = '0;
      if (!lock && deb_diff) begin
         if (deb_flip) deb_lvl_next = !deb_lvl_reg;
         else          deb_cnt_next = deb_cnt_reg + 1'b1;
      end
      if (!lock && deb_lvl_reg)
         hold_cnt_next = (hold_cnt_reg == HOLD_MAX) ? hold_cnt_reg : hold_cnt_reg + 1'b1;
      // Outside ON the idle counter sits at 0, which also covers entry to ON.
      if (state_reg == S_ON && !idle_clr)
         idle_cnt_next = (idle_cnt_reg == IDLE_MAX) ? idle_cnt_reg : idle_cnt_reg + 1'b1;
   end

   // Sequencer state machine.
   always_comb begin
      state_next  = state_reg;
      pwr_en_next = pwr_en_reg;
      enter_seq   = 1'b0;
      case (state_reg)
         S_OFF: begin
            if (short_evt) begin
               state_next = S_UP;
               enter_seq  = 1'b1;
            end
         end
         S_UP: begin
            if (long_evt) begin
               state_next  = S_OFF;
               pwr_en_next = '0;
            end else if (main_done || short_evt) begin
               state_next = S_DOWN;
               enter_seq  = 1'b1;
            end else if (step_tick) begin
               pwr_en_next = up_val;
               if (up_val[NCH-1]) state_next = S_ON;
            end
         end
         S_ON: begin
            if (long_evt) begin
               state_next  = S_OFF;
               pwr_en_next = '0;
            end else if (main_done || idle_exp || short_evt) begin
               state_next = S_DOWN;
               enter_seq  = 1'b1;
            end
         end
         default: begin // S_DOWN
            if (long_evt) begin
               state_next  = S_OFF;
               pwr_en_next = '0;
            end else if (short_evt && !main_done) begin
               state_next = S_UP;
               enter_seq  = 1'b1;
            end else if (step_tick) begin
               pwr_en_next = dn_val;
               if (dn_val == '0) state_next = S_OFF;
            end
         end
      endcase

      // Preloading the last count makes the first rail change land one
      // cycle after entry; a reversal restarts the interval the same way.
      if (enter_seq)
         step_cnt_next = STEP_LAST;
      else if (state_next == state_reg && (state_reg == S_UP || state_reg == S_DOWN))
         step_cnt_next = step_tick ? '0 : step_cnt_reg + 1'b1;
      else
         step_cnt_next = '0;

      led_next  = (state_next != S_OFF);
      busy_next = (state_next == S_UP) || (state_next == S_DOWN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_meta_reg   <= 1'b0;
         a_sync_reg   <= 1'b0;
         deb_lvl_reg  <= 1'b0;
         deb_cnt_reg  <= '0;
         hold_cnt_reg <= '0;
         idle_cnt_reg <= '0;
         step_cnt_reg <= '0;
         state_reg    <= S_OFF;
         pwr_en_reg   <= '0;
         led_reg      <= 1'b0;
         busy_reg     <= 1'b0;
      end else begin
         a_meta_reg   <= a_pwr;
         a_sync_reg   <= a_meta_reg;
         deb_lvl_reg  <= deb_lvl_next;
         deb_cnt_reg  <= deb_cnt_next;
         hold_cnt_reg <= hold_cnt_next;
         idle_cnt_reg <= idle_cnt_next;
         step_cnt_reg <= step_cnt_next;
         state_reg    <= state_next;
         pwr_en_reg   <= pwr_en_next;
         led_reg      <= led_next;
         busy_reg     <= busy_next;
      end
   end

   assign pwr_en  = pwr_en_reg;
   assign led_pwr = led_reg;
   assign busy    = busy_reg;
   assign st      = state_reg;

endmodule

// File: tb/tb_power_seq.sv
// ---------------------------------------------------------------------------
// tb_power_seq : self-checking bench for power_seq
//
// Stimulus pushes the expected output changes ({pwr_en, st, led_pwr, busy}
// with the cycle they are due) onto a queue; a negedge monitor pops each
// entry on its due cycle and compares, and flags any change nobody asked for.
// ---------------------------------------------------------------------------
module tb_power_seq;

   localparam int NCH  = 3;
   localparam int DEB  = 4;
   localparam int STEP = 8;
   localparam int HOLD = 40;
   localparam int IDLE = 100;
   localparam int DLAT = DEB + 2;   // synchroniser plus debounce latency

   localparam logic [1:0] S_OFF  = 2'd0;
   localparam logic [1:0] S_UP   = 2'd1;
   localparam logic [1:0] S_ON   = 2'd2;
   localparam logic [1:0] S_DOWN = 2'd3;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic           a_pwr = 1'b0;
   logic           main_done = 1'b0;
   logic           activity = 1'b0;
   logic           lock = 1'b0;
   logic [NCH-1:0] pwr_en;
   logic           led_pwr;
   logic           busy;
   logic [1:0]     st;

   power_seq #(
      .NCH(NCH), .DEB_CMAX(DEB), .STEP_CMAX(STEP),
      .HOLD_CMAX(HOLD), .IDLE_CMAX(IDLE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .a_pwr(a_pwr), .main_done(main_done),
      .activity(activity), .lock(lock), .pwr_en(pwr_en),
      .led_pwr(led_pwr), .busy(busy), .st(st)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [6:0] val;
   } exp_t;

   exp_t       exp_q[$];
   int         errors = 0;
   int         checks = 0;
   logic       mon_en = 1'b0;
   logic [6:0] obs;
   logic [6:0] cur_exp = 7'd0;
   logic [6:0] last_obs = 7'd0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
      end else begin
         $display("check %s ok: %0h (cycle %0d)", tag, got, cyc);
      end
   endtask

   function automatic logic [6:0] tup(input logic [NCH-1:0] p, input logic [1:0] s);
      return {p, s, (s != S_OFF), (s == S_UP || s == S_DOWN)};
   endfunction

   task automatic push(input int c, input logic [NCH-1:0] p, input logic [1:0] s);
      exp_t e;
      e.cyc = c;
      e.val = tup(p, s);
      exp_q.push_back(e);
   endtask

   // Power-up from pwr_en=p entered at edge e: one more rail at e+1, then
   // every STEP cycles; the edge filling the last rail also enters ON.
   task automatic push_up(input int e, input logic [NCH-1:0] p_in);
      logic [NCH-1:0] p;
      int c;
      p = p_in;
      c = e + 1;
      push(e, p, S_UP);
      while (p != '1) begin
         p = {p[NCH-2:0], 1'b1};
         push(c, p, (p == '1) ? S_ON : S_UP);
         c += STEP;
      end
   endtask

   task automatic push_dn(input int e, input logic [NCH-1:0] p_in);
      logic [NCH-1:0] p;
      int c;
      p = p_in;
      c = e + 1;
      push(e, p, S_DOWN);
      while (p != '0) begin
         p = p >> 1;
         push(c, p, (p == '0) ? S_OFF : S_DOWN);
         c += STEP;
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int len);
      a_pwr = 1'b1;
      tick(len);
      a_pwr = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      tick(1);
      check_val("drain", exp_q.size(), 0);
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (mon_en) begin
         obs = {pwr_en, st, led_pwr, busy};
         if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            cur_exp = exp_q[0].val;
            void'(exp_q.pop_front());
            check_val("step", obs, cur_exp);
         end else if (obs != last_obs) begin
            check_val("spurious", obs, cur_exp);
         end
         last_obs = obs;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   int p0, e1, eon, act;

   initial begin
      #1 rst_n = 1'b0;
      tick(3);
      check_val("rst_pwr_en", pwr_en, 0);
      check_val("rst_st", st, S_OFF);
      check_val("rst_led", led_pwr, 0);
      check_val("rst_busy", busy, 0);
      rst_n = 1'b1;
      tick(2);
      mon_en = 1'b1;

      // 1: short press from OFF -> full power-up
      p0 = cyc;
      push_up(p0 + 12 + DLAT, '0);
      press(12);
      drain(100);

      // 2: short press in ON -> full power-down
      p0 = cyc;
      push_dn(p0 + 12 + DLAT, '1);
      press(12);
      drain(100);

      // 3: reversal in UP one cycle after pwr_en reaches 011
      p0 = cyc;
      e1 = p0 + 12 + DLAT;
      push(e1, 3'b000, S_UP);
      push(e1 + 1, 3'b001, S_UP);
      push(e1 + 1 + STEP, 3'b011, S_UP);
      push_dn(e1 + 4 + DLAT, 3'b011);
      press(12);
      tick(e1 - cyc);
      press(4);
      drain(100);

      // 4: long press in ON forces OFF; the release does nothing
      p0 = cyc;
      push_up(p0 + 12 + DLAT, '0);
      press(12);
      drain(100);
      p0 = cyc;
      push(p0 + DLAT + HOLD, 3'b000, S_OFF);
      press(60);
      tick(20);
      drain(10);

      // 5: locked press ignored, main_done powers down, activity delays idle
      p0 = cyc;
      push_up(p0 + 12 + DLAT, '0);
      press(12);
      drain(100);
      lock = 1'b1;
      press(12);
      tick(4);
      lock = 1'b0;
      tick(4);
      p0 = cyc;
      push_dn(p0 + 1, '1);
      main_done = 1'b1;
      tick(1);
      main_done = 1'b0;
      drain(100);
      p0 = cyc;
      eon = p0 + 12 + DLAT + 1 + 2 * STEP;
      act = eon + 90;
      push_up(p0 + 12 + DLAT, '0);
      push_dn(act + IDLE, '1);
      press(12);
      tick(act - 1 - cyc);
      activity = 1'b1;
      tick(1);
      activity = 1'b0;
      drain(200);

      // 6: asynchronous reset mid-UP, then the block waits for a new press
      p0 = cyc;
      e1 = p0 + 12 + DLAT;
      push(e1, 3'b000, S_UP);
      push(e1 + 1, 3'b001, S_UP);
      push(e1 + 1 + STEP, 3'b011, S_UP);
      press(12);
      tick(e1 + 12 - cyc);
      push(cyc + 1, 3'b000, S_OFF);
      #2 rst_n = 1'b0;
      #1;
      check_val("async_rst_pwr_en", pwr_en, 0);
      check_val("async_rst_st", st, S_OFF);
      tick(3);
      rst_n = 1'b1;
      tick(30);
      p0 = cyc;
      push_up(p0 + 12 + DLAT, '0);
      press(12);
      drain(100);

      tick(5);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
